// File: rtl/avalon_pixel_writer.sv
// Avalon-MM pixel writer: one single-word write per 24-bit pixel, row-strided addressing.
// Optional macro WRITE_RESP_EN adds write-response tracking and an outstanding-write limit.
module avalon_pixel_writer #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ROW_STRIDE = 2560,
  parameter int unsigned MAX_OUTST  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              word_valid,
  input  logic [23:0]       word_data,
  output logic              word_ready,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_write,
  output logic [31:0]       master_writedata,
  output logic [3:0]        master_byteenable,
  input  logic              master_waitrequest,
  input  logic              master_writeresponsevalid,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ColW-1:0]   LastCol   = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0]   LastRow   = RowW'(IMG_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] Stride    = ADDR_W'(ROW_STRIDE);
  localparam logic [ADDR_W-1:0] WordBytes = ADDR_W'(4);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_start_q, row_start_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [23:0]       pix_q, pix_d;
  logic              wr_done;
  logic              can_issue;
  logic              drained;

`ifdef WRITE_RESP_EN
  localparam int unsigned OutW = $clog2(MAX_OUTST + 1);

  logic [OutW-1:0] outst_q, outst_d;
  logic            resp_dec;

  // A response with nothing outstanding is ignored so the count cannot underflow.
  assign resp_dec  = master_writeresponsevalid && (outst_q != '0);
  assign can_issue = (outst_q != OutW'(MAX_OUTST));
  assign drained   = (outst_q == '0);

  always_comb begin
    outst_d = outst_q;
    if (wr_done && !resp_dec) begin
      outst_d = outst_q + 1'b1;
    end else if (!wr_done && resp_dec) begin
      outst_d = outst_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      outst_q <= '0;
    end else begin
      outst_q <= outst_d;
    end
  end
`else
  logic unused_resp;

  assign unused_resp = master_writeresponsevalid;
  assign can_issue   = 1'b1;
  assign drained     = 1'b1;
`endif

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    row_start_d       = row_start_q;
    col_d             = col_q;
    row_d             = row_q;
    pix_d             = pix_q;
    word_ready        = 1'b0;
    master_write      = 1'b0;
    master_byteenable = 4'b0000;
    frame_done        = 1'b0;
    wr_done           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFetch;
          addr_d      = base_addr;
          row_start_d = base_addr;
          col_d       = '0;
          row_d       = '0;
        end
      end
      StFetch: begin
        word_ready = can_issue;
        if (word_valid && can_issue) begin
          pix_d   = word_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        master_write      = 1'b1;
        master_byteenable = 4'b0111;
        if (!master_waitrequest) begin
          wr_done = 1'b1;
          if (col_q == LastCol) begin
            col_d       = '0;
            row_start_d = row_start_q + Stride;
            addr_d      = row_start_q + Stride;
            row_d       = row_q + 1'b1;
          end else begin
            col_d  = col_q + 1'b1;
            addr_d = addr_q + WordBytes;
          end
          state_d = ((row_q == LastRow) && (col_q == LastCol)) ? StDone : StFetch;
        end
      end
      StDone: begin
        if (drained) begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      row_start_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_start_q <= row_start_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pix_q       <= pix_d;
    end
  end

  assign master_address   = addr_q;
  assign master_writedata = {8'h00, pix_q};
  assign busy             = (state_q != StIdle);

endmodule
